// File: rtl/vga_timing_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_if: pixel-stream counters and strobes for the video chain|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface vga_timing_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_tick;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_tick
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing: 1024x768@60 counters, sync/blank strobes, frame tick    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0
) (
    input  wire              clk,
    input  wire              rst,
    vga_timing_if.master     vga_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] C_H_ACTIVE = 11'(H_ACTIVE);
    localparam logic [10:0] C_V_ACTIVE = 11'(V_ACTIVE);
    localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        tick_q, tick_d;

    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == C_H_LAST) begin
            hcount_d = 11'd0;
            vcount_d = (vcount_q == C_V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end
    end

    // Strobes decode the next counter values so they register alongside them.
    always_comb begin
        hblnk_d = (hcount_d >= C_H_ACTIVE);
        vblnk_d = (vcount_d >= C_V_ACTIVE);
        hsync_d = ((hcount_d >= C_HS_START) && (hcount_d <= C_HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vcount_d >= C_VS_START) && (vcount_d <= C_VS_END)) ? SYNC_POL : ~SYNC_POL;
        tick_d  = (hcount_d == C_H_LAST) && (vcount_d == C_V_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            tick_q   <= tick_d;
        end
    end

    assign vga_o.hcount     = hcount_q;
    assign vga_o.vcount     = vcount_q;
    assign vga_o.hsync      = hsync_q;
    assign vga_o.vsync      = vsync_q;
    assign vga_o.hblnk      = hblnk_q;
    assign vga_o.vblnk      = vblnk_q;
    assign vga_o.frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_timing: directed tests on default and reduced timing         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def;
    logic rst_sm;

    vga_timing_if if_def();
    vga_timing_if if_sm();

    vga_timing u_def (
        .clk   (clk),
        .rst   (rst_def),
        .vga_o (if_def)
    );

    vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1)
    ) u_sm (
        .clk   (clk),
        .rst   (rst_sm),
        .vga_o (if_sm)
    );

    int total = 0;
    int bad   = 0;

    task automatic do_reset_def();
        rst_def = 1'b1;
        @(negedge clk);
        rst_def = 1'b0;
    endtask

    task automatic do_reset_sm();
        rst_sm = 1'b1;
        @(negedge clk);
        rst_sm = 1'b0;
    endtask

    task automatic test_reset();
        rst_def = 1'b1;
        rst_sm  = 1'b1;
        repeat (2) @(negedge clk);
        rst_def = 1'b0;
        rst_sm  = 1'b0;
        repeat (37) @(negedge clk);
        rst_def = 1'b1;
        rst_sm  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (if_def.hcount !== 11'd0 || if_def.vcount !== 11'd0 || if_def.hblnk !== 1'b0 ||
                if_def.vblnk !== 1'b0 || if_def.hsync !== 1'b1 || if_def.vsync !== 1'b1 ||
                if_def.frame_tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_def cyc%0d: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ft=%b, want 0 0 0 0 1 1 0",
                         i, if_def.hcount, if_def.vcount, if_def.hblnk, if_def.vblnk,
                         if_def.hsync, if_def.vsync, if_def.frame_tick);
            end
            total++;
            if (if_sm.hcount !== 11'd0 || if_sm.vcount !== 11'd0 || if_sm.hblnk !== 1'b0 ||
                if_sm.vblnk !== 1'b0 || if_sm.hsync !== 1'b0 || if_sm.vsync !== 1'b0 ||
                if_sm.frame_tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_sm cyc%0d: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ft=%b, want 0 0 0 0 0 0 0",
                         i, if_sm.hcount, if_sm.vcount, if_sm.hblnk, if_sm.vblnk,
                         if_sm.hsync, if_sm.vsync, if_sm.frame_tick);
            end
        end
        rst_def = 1'b0;
        rst_sm  = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            total++;
            if (if_def.hcount !== 11'(k) || if_def.vcount !== 11'd0) begin
                bad++;
                $display("FAIL release_def step%0d: got (%0d,%0d) want (%0d,0)",
                         k, if_def.hcount, if_def.vcount, k);
            end
            total++;
            if (if_sm.hcount !== 11'(k) || if_sm.vcount !== 11'd0) begin
                bad++;
                $display("FAIL release_sm step%0d: got (%0d,%0d) want (%0d,0)",
                         k, if_sm.hcount, if_sm.vcount, k);
            end
        end
    endtask

    task automatic test_line_timing();
        int blnk_rise, hs_first, hs_last, hs_cnt, seq_err, other_err;
        blnk_rise = -1; hs_first = -1; hs_last = -1; hs_cnt = 0; seq_err = 0; other_err = 0;
        do_reset_def();
        for (int c = 0; c < 1344; c++) begin
            if (if_def.hcount !== 11'(c) || if_def.vcount !== 11'd0) seq_err++;
            if (if_def.vsync !== 1'b1 || if_def.vblnk !== 1'b0 || if_def.frame_tick !== 1'b0) other_err++;
            if (if_def.hblnk === 1'b1 && blnk_rise < 0) blnk_rise = c;
            if (if_def.hsync === 1'b0) begin
                if (hs_first < 0) hs_first = c;
                hs_last = c;
                hs_cnt++;
            end
            @(negedge clk);
        end
        total++;
        if (seq_err !== 0) begin bad++; $display("FAIL line_seq: got %0d bad steps want 0", seq_err); end
        total++;
        if (other_err !== 0) begin bad++; $display("FAIL line_vstrobes: got %0d bad steps want 0", other_err); end
        total++;
        if (blnk_rise !== 1024) begin bad++; $display("FAIL hblnk_rise: got %0d want 1024", blnk_rise); end
        total++;
        if (hs_first !== 1048 || hs_last !== 1183) begin
            bad++; $display("FAIL hsync_window: got %0d..%0d want 1048..1183", hs_first, hs_last);
        end
        total++;
        if (hs_cnt !== 136) begin bad++; $display("FAIL hsync_width: got %0d want 136", hs_cnt); end
        total++;
        if (if_def.hcount !== 11'd0 || if_def.vcount !== 11'd1 || if_def.hblnk !== 1'b0 || if_def.hsync !== 1'b1) begin
            bad++;
            $display("FAIL line_wrap: got (%0d,%0d) hb=%b hs=%b want (0,1) hb=0 hs=1",
                     if_def.hcount, if_def.vcount, if_def.hblnk, if_def.hsync);
        end
        repeat (1343) @(negedge clk);
        total++;
        if (if_def.hcount !== 11'd1343 || if_def.vcount !== 11'd1) begin
            bad++; $display("FAIL line2_end: got (%0d,%0d) want (1343,1)", if_def.hcount, if_def.vcount);
        end
        @(negedge clk);
        total++;
        if (if_def.hcount !== 11'd0 || if_def.vcount !== 11'd2) begin
            bad++; $display("FAIL line_period: got (%0d,%0d) want (0,2)", if_def.hcount, if_def.vcount);
        end
    endtask

    task automatic test_hsync_reset();
        do_reset_def();
        repeat (1183) @(negedge clk);
        total++;
        if (if_def.hcount !== 11'd1183 || if_def.hsync !== 1'b0) begin
            bad++; $display("FAIL pre_reset_def: got h=%0d hs=%b want h=1183 hs=0", if_def.hcount, if_def.hsync);
        end
        rst_def = 1'b1;
        @(negedge clk);
        rst_def = 1'b0;
        total++;
        if (if_def.hcount !== 11'd0 || if_def.vcount !== 11'd0 || if_def.hsync !== 1'b1 || if_def.hblnk !== 1'b0) begin
            bad++;
            $display("FAIL midreset_def: got (%0d,%0d) hs=%b hb=%b want (0,0) hs=1 hb=0",
                     if_def.hcount, if_def.vcount, if_def.hsync, if_def.hblnk);
        end
        @(negedge clk);
        total++;
        if (if_def.hcount !== 11'd1 || if_def.vcount !== 11'd0) begin
            bad++; $display("FAIL midreset_def_restart: got (%0d,%0d) want (1,0)", if_def.hcount, if_def.vcount);
        end
    endtask

    task automatic test_small_frame();
        int eh, ev, ticks, t0, t1, edge_err;
        logic e_hb, e_vb, e_hs, e_vs, e_ft, prev_vs;
        eh = 0; ev = 0; ticks = 0; t0 = -1; t1 = -1; edge_err = 0; prev_vs = 1'b0;
        do_reset_sm();
        for (int c = 0; c < 196; c++) begin
            e_hb = (eh >= 8);
            e_vb = (ev >= 4);
            e_hs = (eh >= 10 && eh <= 11);
            e_vs = (ev == 5);
            e_ft = (eh == 13 && ev == 6);
            total++;
            if (if_sm.hcount !== 11'(eh) || if_sm.vcount !== 11'(ev) || if_sm.hblnk !== e_hb ||
                if_sm.vblnk !== e_vb || if_sm.hsync !== e_hs || if_sm.vsync !== e_vs ||
                if_sm.frame_tick !== e_ft) begin
                bad++;
                $display("FAIL sb_sm c%0d: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ft=%b want h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ft=%b",
                         c, if_sm.hcount, if_sm.vcount, if_sm.hblnk, if_sm.vblnk, if_sm.hsync,
                         if_sm.vsync, if_sm.frame_tick, eh, ev, e_hb, e_vb, e_hs, e_vs, e_ft);
            end
            if (c > 0 && if_sm.vsync !== prev_vs && if_sm.hcount !== 11'd0) edge_err++;
            prev_vs = if_sm.vsync;
            if (if_sm.frame_tick === 1'b1) begin
                ticks++;
                if (t0 < 0) t0 = c; else t1 = c;
            end
            if (eh == 13) begin
                eh = 0;
                ev = (ev == 6) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
            @(negedge clk);
        end
        total++;
        if (ticks !== 2 || t0 !== 97 || t1 !== 195) begin
            bad++; $display("FAIL tick_period_sm: got n=%0d at %0d,%0d want n=2 at 97,195", ticks, t0, t1);
        end
        total++;
        if (edge_err !== 0) begin bad++; $display("FAIL vsync_edge_sm: got %0d off-hcount0 edges want 0", edge_err); end
        total++;
        if (if_sm.hcount !== 11'd0 || if_sm.vcount !== 11'd0) begin
            bad++; $display("FAIL frame_wrap_sm: got (%0d,%0d) want (0,0)", if_sm.hcount, if_sm.vcount);
        end
    endtask

    task automatic test_mid_reset();
        int first;
        first = -1;
        do_reset_sm();
        repeat (81) @(negedge clk);
        total++;
        if (if_sm.hcount !== 11'd11 || if_sm.vcount !== 11'd5 || if_sm.hsync !== 1'b1 || if_sm.vsync !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_sm: got (%0d,%0d) hs=%b vs=%b want (11,5) hs=1 vs=1",
                     if_sm.hcount, if_sm.vcount, if_sm.hsync, if_sm.vsync);
        end
        rst_sm = 1'b1;
        @(negedge clk);
        rst_sm = 1'b0;
        total++;
        if (if_sm.hcount !== 11'd0 || if_sm.vcount !== 11'd0 || if_sm.hsync !== 1'b0 ||
            if_sm.vsync !== 1'b0 || if_sm.vblnk !== 1'b0 || if_sm.frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL midreset_sm: got (%0d,%0d) hs=%b vs=%b vb=%b ft=%b want (0,0) 0 0 0 0",
                     if_sm.hcount, if_sm.vcount, if_sm.hsync, if_sm.vsync, if_sm.vblnk, if_sm.frame_tick);
        end
        for (int c = 0; c < 200; c++) begin
            if (if_sm.frame_tick === 1'b1) begin
                first = c;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (first !== 97 || if_sm.hcount !== 11'd13 || if_sm.vcount !== 11'd6) begin
            bad++;
            $display("FAIL first_tick_sm: got step=%0d at (%0d,%0d) want step=97 at (13,6)",
                     first, if_sm.hcount, if_sm.vcount);
        end
    endtask

    initial begin
        rst_def = 1'b1;
        rst_sm  = 1'b1;
        test_reset();
        test_line_timing();
        test_hsync_reset();
        test_small_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Source end of the pixel-stream interface consumed by the drawing stages (menu, road, car layers).
- Generates the 11-bit horizontal/vertical counters plus sync and blanking strobes for 1024x768 @ 60 Hz (65 MHz pixel clock).
- Adds a one-cycle end-of-frame pulse so downstream stages can update per-frame state.
- Sits first in the video chain; its outputs feed the hcount_in/vcount_in/hsync_in/vsync_in/hblnk_in/vblnk_in inputs of the first drawing stage.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low, 1 = active-high)

Ports:
- clk  input  1  pixel clock, 65 MHz; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- hcount  output  11  current pixel column, 0..H_TOTAL-1
- vcount  output  11  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- hblnk  output  1  high when hcount >= H_ACTIVE
- vblnk  output  1  high when vcount >= V_ACTIVE
- frame_tick  output  1  one-cycle pulse on the last pixel of the frame

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
  - Both must be ≤ 2048 (11-bit counters). Out-of-range values are unsupported; no check is made at runtime.
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values, applied at the first rising edge with rst=1:
  - hcount=0, vcount=0, hblnk=0, vblnk=0, frame_tick=0.
  - hsync and vsync at their inactive level (~SYNC_POL).
- Counting:
  - hcount increments by 1 every cycle.
  - At hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At hcount==H_TOTAL-1 with vcount==V_TOTAL-1, both wrap to 0.
  - No stall or enable; the frame period is exactly H_TOTAL*V_TOTAL cycles.
- Output alignment:
  - Every output is a register.
  - In any cycle, hsync/vsync/hblnk/vblnk/frame_tick describe the hcount/vcount value present in that same cycle.
  - Zero skew between counters and strobes. The implementation decodes next-state counts into the strobe registers.
- Decode:
  - hblnk = (hcount >= H_ACTIVE).
  - vblnk = (vcount >= V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1, else ~SYNC_POL. Default active window is 1048..1183.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1, else ~SYNC_POL. Default active window is 771..776.
  - vsync transitions coincide with hcount==0 of the relevant line.
  - frame_tick = 1 only when hcount==H_TOTAL-1 and vcount==V_TOTAL-1, so exactly one cycle per frame.
- Reset mid-frame:
  - The next cycle shows the reset values regardless of counter position.
  - Counting restarts from (0,0) on the first cycle with rst=0.
  - No partial frame_tick is produced.
- First cycle after reset release: hcount=0, vcount=0 (first visible pixel). The next cycle shows hcount=1.

Test Plan:
- Reset: hold rst=1 for 3 cycles at an arbitrary counter position -> hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=1, vsync=1, frame_tick=0. First cycle after release is (0,0) and the next is (1,0).
- Line timing (defaults): run one line from (0,0):
  - hblnk rises at hcount=1024.
  - hsync=0 exactly for hcount 1048..1183 (136 cycles).
  - hcount wraps 1343->0 with vcount 0->1.
  - Line period is 1344 cycles.
- Frame timing (defaults): run a full frame:
  - vblnk=1 for vcount 768..805.
  - vsync=0 for vcount 771..776 (6*1344=8064 cycles), with edges at hcount=0.
  - frame_tick high exactly once, at (1343,805).
  - Next cycle is (0,0); tick-to-tick spacing is 1083264 cycles.
- Reduced parameters: H 8/2/2/2, V 4/1/1/1, SYNC_POL=1:
  - H_TOTAL=14, V_TOTAL=7, frame_tick period 98 cycles.
  - hsync=1 for hcount 10..11; vsync=1 for vcount 5.
  - hblnk for hcount 8..13; vblnk for vcount 4..6.
- Mid-operation reset: assert rst for 1 cycle at (1183,776), inside both sync pulses -> syncs return inactive in the following cycle, counters restart at (0,0), and no frame_tick is produced until (1343,805) of the new frame.
- Consistency check: scoreboard over 2 full frames compares every output each cycle against the decode equations above -> zero mismatches.
